// File: rtl/rr_mux_8_pkg.sv
// Shared constants, state encoding and pointer helper for the 8-source round-robin collector.
package rr_mux_8_pkg;

   localparam int NUM_SRC = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/rr_mux_8_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo 8.
module rr_arb_8
   import rr_mux_8_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [SEL_W-1:0]   gnt_idx,
   output logic               any
);

   always_comb begin
      logic [SEL_W-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = ptr + k[SEL_W-1:0];
         if (!any && req[idx]) begin
            any          = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux_8.sv
// 8-to-1 round-robin collector with a one-word registered output stage.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX_LOCK_EN.
module rr_mux_8
   import rr_mux_8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC-1:0]         in_valid,
   input  logic [NUM_SRC*WIDTH-1:0]   in_data,
   output logic [NUM_SRC-1:0]         in_ready,
`ifdef RR_MUX_LOCK_EN
   input  logic [NUM_SRC-1:0]         in_last,
   output logic                       out_last,
`endif
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [SEL_W-1:0]           out_sel,
   input  logic                       out_ready
);

   state_t               state, state_nx;
   logic [SEL_W-1:0]     ptr, ptr_nx;
   logic [NUM_SRC-1:0]   req, gnt;
   logic [SEL_W-1:0]     gnt_idx;
   logic                 any;
   logic                 can_load, load;
   logic [WIDTH-1:0]     win_data;

`ifdef RR_MUX_LOCK_EN
   logic                 locked;
   logic [SEL_W-1:0]     lock_idx;

   // While a packet is open only its owner is visible to the arbiter.
   assign req    = locked ? (in_valid & (NUM_SRC'(1) << lock_idx)) : in_valid;
   assign ptr_nx = in_last[gnt_idx] ? rr_next(gnt_idx) : ptr;
`else
   assign req    = in_valid;
   assign ptr_nx = rr_next(gnt_idx);
`endif

   rr_arb_8 u_arb (
      .req     (req),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   // Reset gating keeps every in_ready low for the whole reset cycle.
   assign can_load  = (state == ST_EMPTY) | out_ready;
   assign load      = rst_n & can_load & any;
   assign in_ready  = gnt & {NUM_SRC{load}};
   assign out_valid = (state == ST_FULL);

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt[i]) win_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_EMPTY: if (load) state_nx = ST_FULL;
         ST_FULL:  if (out_ready && !load) state_nx = ST_EMPTY;
         default:  state_nx = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         ptr      <= '0;
         out_data <= '0;
         out_sel  <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            out_data <= win_data;
            out_sel  <= gnt_idx;
            ptr      <= ptr_nx;
         end
      end
   end

`ifdef RR_MUX_LOCK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         locked   <= 1'b0;
         lock_idx <= '0;
         out_last <= 1'b0;
      end else if (load) begin
         locked   <= ~in_last[gnt_idx];
         lock_idx <= gnt_idx;
         out_last <= in_last[gnt_idx];
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux_8.sv
// Directed self-checking bench for rr_mux_8; lock scenario runs when RR_MUX_LOCK_EN is defined.
module tb_rr_mux_8;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [7:0]   in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]   in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [2:0]   out_sel;
   logic         out_ready;
`ifdef RR_MUX_LOCK_EN
   logic [7:0]   in_last;
   logic         out_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rr_mux_8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grant(input string tag, input logic [7:0] exp_rdy,
                        input logic [2:0] exp_sel, input logic [7:0] exp_data);
      #1;
      check_eq({tag, "_rdy"}, {24'h0, in_ready}, {24'h0, exp_rdy});
      tick();
      check_eq({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
      check_eq({tag, "_sel"}, {29'h0, out_sel}, {29'h0, exp_sel});
      check_eq({tag, "_data"}, {24'h0, out_data}, {24'h0, exp_data});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
`ifdef RR_MUX_LOCK_EN
      in_last = 8'hFF;
`endif

      // Reset held two cycles with every source requesting.
      for (int c = 0; c < 2; c++) begin
         #1;
         check_eq("rst_rdy", {24'h0, in_ready}, 32'h0);
         tick();
         check_eq("rst_vld", {31'h0, out_valid}, 32'h0);
         check_eq("rst_sel", {29'h0, out_sel}, 32'h0);
         check_eq("rst_data", {24'h0, out_data}, 32'h0);
`ifdef RR_MUX_LOCK_EN
         check_eq("rst_last", {31'h0, out_last}, 32'h0);
`endif
      end

      // Fairness: 16 grants rotating from source 0.
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         grant("fair", 8'(1 << (k % 8)), 3'(k % 8), 8'h10 + 8'(k % 8));
      end

      // Single source 5 with data A5; ptr then sits at 6.
      in_valid = 8'h20;
      in_data[5*W +: W] = 8'hA5;
      grant("single5", 8'h20, 3'd5, 8'hA5);
      in_valid = 8'hFF;
      grant("after5", 8'h40, 3'd6, 8'h16);

      // Pointer wrap 7 -> 0.
      in_valid = 8'h81;
      grant("wrap7", 8'h80, 3'd7, 8'h17);
      grant("wrap0", 8'h01, 3'd0, 8'h10);

      // Backpressure: source 2 held while out_ready low.
      in_valid = 8'h04;
      grant("bp_load2", 8'h04, 3'd2, 8'h12);
      in_valid  = 8'h0C;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_eq("bp_rdy", {24'h0, in_ready}, 32'h0);
         tick();
         check_eq("bp_vld", {31'h0, out_valid}, 32'h1);
         check_eq("bp_sel", {29'h0, out_sel}, 32'h2);
         check_eq("bp_data", {24'h0, out_data}, 32'h12);
      end
      out_ready = 1'b1;
      grant("bp_load3", 8'h08, 3'd3, 8'h13);

      // Drain to empty; output fields hold.
      in_valid = 8'h00;
      #1;
      check_eq("drain_rdy", {24'h0, in_ready}, 32'h0);
      tick();
      check_eq("drain_vld", {31'h0, out_valid}, 32'h0);
      check_eq("drain_sel", {29'h0, out_sel}, 32'h3);
      check_eq("drain_data", {24'h0, out_data}, 32'h13);

      // Empty accepts even with out_ready low; then reset discards the word.
      out_ready = 1'b0;
      in_valid  = 8'hFF;
      grant("empty_load", 8'h10, 3'd4, 8'h14);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_rdy", {24'h0, in_ready}, 32'h0);
      tick();
      check_eq("mid_rst_vld", {31'h0, out_valid}, 32'h0);
      check_eq("mid_rst_sel", {29'h0, out_sel}, 32'h0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      grant("post_rst", 8'h01, 3'd0, 8'h10);

`ifdef RR_MUX_LOCK_EN
      // Source 1 sends a 3-beat packet while source 2 competes.
      in_valid = 8'h06;
      in_last  = 8'h00;
      grant("lock_b0", 8'h02, 3'd1, 8'h11);
      check_eq("lock_b0_last", {31'h0, out_last}, 32'h0);
      grant("lock_b1", 8'h02, 3'd1, 8'h11);
      check_eq("lock_b1_last", {31'h0, out_last}, 32'h0);
      in_last = 8'h06;
      grant("lock_b2", 8'h02, 3'd1, 8'h11);
      check_eq("lock_b2_last", {31'h0, out_last}, 32'h1);
      grant("lock_next", 8'h04, 3'd2, 8'h12);
      check_eq("lock_next_last", {31'h0, out_last}, 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
